// File: rtl/button_event_decoder_pkg.sv
// Shared helpers for the button event decoder slice.
package button_event_decoder_pkg;

  // Constant function, so it can size the shared counter at elaboration.
  function automatic int unsigned maxCnt(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_decoder_edge_detector.sv
// Rise/fall detector against a registered previous sample; outputs are combinational.
module edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;
  assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button into press/release, short, long and double events.
module button_event_decoder
  import button_event_decoder_pkg::*;
#(
  parameter int unsigned LONG_PRESS_CNT = 25_000_000,
  parameter int unsigned DOUBLE_GAP_CNT = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press,
  output logic o_release,
  output logic o_short,
  output logic o_long,
  output logic o_double,
  output logic o_busy
);

  localparam int unsigned CW = $clog2(maxCnt(LONG_PRESS_CNT, DOUBLE_GAP_CNT) + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_LONG   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_PRESS2 = 3'd4;

  // The counter is cleared on the deciding edge, so the Nth later edge sees N-1.
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CNT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_GAP_CNT - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  if (LONG_PRESS_CNT < 2 || DOUBLE_GAP_CNT < 2) begin : g_badParams
    $error("button_event_decoder: LONG_PRESS_CNT and DOUBLE_GAP_CNT must both be >= 2");
  end

  logic          w_rise;
  logic          w_fall;
  logic [2:0]    r_state;
  logic [2:0]    w_nextState;
  logic [CW-1:0] r_count;
  logic          w_clrCnt;
  logic          w_short;
  logic          w_long;
  logic          w_double;

  edge_detector u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (i_btn),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_comb begin
    w_nextState = r_state;
    w_clrCnt    = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    w_double    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_nextState = ST_PRESS1;
          w_clrCnt    = 1'b1;
        end
      end
      ST_PRESS1: begin
        if (w_fall) begin
          w_nextState = ST_GAP;
          w_clrCnt    = 1'b1;
        end else if (r_count == LONG_LAST) begin
          w_nextState = ST_LONG;
          w_long      = 1'b1;
        end
      end
      ST_LONG: begin
        if (w_fall) w_nextState = ST_IDLE;
      end
      // A rise on the final gap edge wins over the short-press timeout.
      ST_GAP: begin
        if (w_rise) begin
          w_nextState = ST_PRESS2;
          w_double    = 1'b1;
        end else if (r_count == GAP_LAST) begin
          w_nextState = ST_IDLE;
          w_short     = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (w_fall) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_short   <= 1'b0;
      o_long    <= 1'b0;
      o_double  <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      o_press   <= w_rise;
      o_release <= w_fall;
      o_short   <= w_short;
      o_long    <= w_long;
      o_double  <= w_double;
      o_busy    <= (w_nextState != ST_IDLE);
      if (w_clrCnt) begin
        r_count <= '0;
      end else if ((r_state == ST_PRESS1 || r_state == ST_GAP) && r_count != CNT_MAX) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_PRESS_CNT=8, DOUBLE_GAP_CNT=5.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic rst;
  logic i_btn;
  logic o_press, o_release, o_short, o_long, o_double, o_busy;

  int errors = 0;
  int checks = 0;

  // Expected vectors are {press, release, short, long, double, busy}.
  localparam logic [5:0] E_IDLE = 6'b000000;
  localparam logic [5:0] E_BUSY = 6'b000001;
  localparam logic [5:0] E_PRS  = 6'b100001;
  localparam logic [5:0] E_REL  = 6'b010001;
  localparam logic [5:0] E_RELI = 6'b010000;
  localparam logic [5:0] E_SHRT = 6'b001000;
  localparam logic [5:0] E_LONG = 6'b000101;
  localparam logic [5:0] E_DBL  = 6'b100011;

  button_event_decoder #(
    .LONG_PRESS_CNT (8),
    .DOUBLE_GAP_CNT (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_btn     (i_btn),
    .o_press   (o_press),
    .o_release (o_release),
    .o_short   (o_short),
    .o_long    (o_long),
    .o_double  (o_double),
    .o_busy    (o_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [5:0] expected);
    logic [5:0] observed;
    observed = {o_press, o_release, o_short, o_long, o_double, o_busy};
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
  endtask

  // Drive one input level, let one edge sample it, then check the registered result.
  task automatic applyStimulus(input logic btn, input int n, input logic [5:0] expected,
                               input string tag);
    for (int i = 0; i < n; i++) begin
      i_btn = btn;
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s[%0d]", tag, i), expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    i_btn = 1'b0;
    applyStimulus(1'b0, 3, E_IDLE, "reset");
    rst = 1'b0;
    applyStimulus(1'b0, 2, E_IDLE, "idle");

    $display("[TB] short press");
    applyStimulus(1'b1, 1, E_PRS,  "short_rise");
    applyStimulus(1'b1, 2, E_BUSY, "short_hold");
    applyStimulus(1'b0, 1, E_REL,  "short_fall");
    applyStimulus(1'b0, 4, E_BUSY, "short_gap");
    applyStimulus(1'b0, 1, E_SHRT, "short_pulse");
    applyStimulus(1'b0, 2, E_IDLE, "short_after");

    $display("[TB] long press");
    applyStimulus(1'b1, 1, E_PRS,  "long_rise");
    applyStimulus(1'b1, 7, E_BUSY, "long_hold");
    applyStimulus(1'b1, 1, E_LONG, "long_pulse");
    applyStimulus(1'b1, 3, E_BUSY, "long_keep");
    applyStimulus(1'b0, 1, E_RELI, "long_fall");
    applyStimulus(1'b0, 7, E_IDLE, "long_after");

    $display("[TB] double press");
    applyStimulus(1'b1, 1, E_PRS,  "dbl_rise1");
    applyStimulus(1'b1, 1, E_BUSY, "dbl_hold1");
    applyStimulus(1'b0, 1, E_REL,  "dbl_fall1");
    applyStimulus(1'b0, 1, E_BUSY, "dbl_gap");
    applyStimulus(1'b1, 1, E_DBL,  "dbl_rise2");
    applyStimulus(1'b1, 1, E_BUSY, "dbl_hold2");
    applyStimulus(1'b0, 1, E_RELI, "dbl_fall2");
    applyStimulus(1'b0, 6, E_IDLE, "dbl_after");

    $display("[TB] second rise at k=5 with a long second hold");
    applyStimulus(1'b1, 1, E_PRS,  "k5_rise1");
    applyStimulus(1'b1, 1, E_BUSY, "k5_hold1");
    applyStimulus(1'b0, 1, E_REL,  "k5_fall1");
    applyStimulus(1'b0, 4, E_BUSY, "k5_gap");
    applyStimulus(1'b1, 1, E_DBL,  "k5_rise2");
    applyStimulus(1'b1, 11, E_BUSY, "k5_hold2");
    applyStimulus(1'b0, 1, E_RELI, "k5_fall2");
    applyStimulus(1'b0, 6, E_IDLE, "k5_after");

    $display("[TB] second rise at k=6");
    applyStimulus(1'b1, 1, E_PRS,  "k6_rise1");
    applyStimulus(1'b1, 1, E_BUSY, "k6_hold1");
    applyStimulus(1'b0, 1, E_REL,  "k6_fall1");
    applyStimulus(1'b0, 4, E_BUSY, "k6_gap");
    applyStimulus(1'b0, 1, E_SHRT, "k6_short");
    applyStimulus(1'b1, 1, E_PRS,  "k6_rise2");
    applyStimulus(1'b0, 1, E_REL,  "k6_fall2");
    applyStimulus(1'b0, 4, E_BUSY, "k6_gap2");
    applyStimulus(1'b0, 1, E_SHRT, "k6_short2");
    applyStimulus(1'b0, 2, E_IDLE, "k6_after");

    $display("[TB] reset during PRESS1");
    applyStimulus(1'b1, 1, E_PRS,  "rst_rise");
    applyStimulus(1'b1, 3, E_BUSY, "rst_hold");
    rst = 1'b1;
    applyStimulus(1'b1, 2, E_IDLE, "rst_active");
    rst = 1'b0;
    applyStimulus(1'b1, 1, E_PRS,  "rst_rerise");
    applyStimulus(1'b1, 1, E_BUSY, "rst_hold2");
    applyStimulus(1'b0, 1, E_REL,  "rst_fall");
    applyStimulus(1'b0, 4, E_BUSY, "rst_gap");
    applyStimulus(1'b0, 1, E_SHRT, "rst_short");
    applyStimulus(1'b0, 2, E_IDLE, "rst_after");

    $display("[TB] short press after reset recovery");
    applyStimulus(1'b1, 1, E_PRS,  "post_rise");
    applyStimulus(1'b0, 1, E_REL,  "post_fall");
    applyStimulus(1'b0, 4, E_BUSY, "post_gap");
    applyStimulus(1'b0, 1, E_SHRT, "post_short");
    applyStimulus(1'b0, 2, E_IDLE, "post_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
